// File: rtl/bp_me_burst_mem_responder.sv
// BP Burst memory responder: memory-side endpoint of the CCE-MEM interface.
// Accepts a command header (plus write beats) and services it against a
// dword-wide memory, answering with a response header (plus read beats).
// Multi-beat bursts wrap inside the block-aligned region, critical word first.
module bp_me_burst_mem_responder #(
  parameter int paddr_width_p   = 40,
  parameter int dword_width_p   = 64,
  parameter int block_width_p   = 512,
  parameter int mem_els_p       = 1024,
  parameter int payload_width_p = 16,
  localparam int header_width_lp = payload_width_p + 3 + paddr_width_p + 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [header_width_lp-1:0] mem_cmd_header_i,
  input  logic                       mem_cmd_header_v_i,
  output logic                       mem_cmd_header_ready_o,
  input  logic [dword_width_p-1:0]   mem_cmd_data_i,
  input  logic                       mem_cmd_data_v_i,
  output logic                       mem_cmd_data_ready_o,

  output logic [header_width_lp-1:0] mem_resp_header_o,
  output logic                       mem_resp_header_v_o,
  input  logic                       mem_resp_header_ready_i,
  output logic [dword_width_p-1:0]   mem_resp_data_o,
  output logic                       mem_resp_data_v_o,
  input  logic                       mem_resp_data_ready_i
);

  localparam int bytes_lp       = dword_width_p / 8;
  localparam int block_words_lp = block_width_p / 64;
  localparam int lg_mem_lp      = $clog2(mem_els_p);
  localparam int size_lsb_lp    = 4 + paddr_width_p;
  localparam logic [lg_mem_lp-1:0] blk_mask_lp = lg_mem_lp'(block_words_lp - 1);

  typedef enum logic [1:0] {IDLE, WDATA, RHDR, RDATA} state_e;
  typedef enum logic [3:0] {MSG_RD = 4'd0, MSG_WR = 4'd1, MSG_UC_RD = 4'd2, MSG_UC_WR = 4'd3} msg_e;

  state_e                     state_q, state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [header_width_lp-1:0] hdr_q, hdr_d;
  logic                       cmd_hdr_rdy_q, cmd_dat_rdy_q, resp_hdr_v_q, resp_dat_v_q;

  logic [dword_width_p-1:0]   mem_q [mem_els_p];

  // Fields of the latched header. Only the address bits that reach the
  // memory index are pulled out; the full header is echoed unchanged.
  logic [3:0]           hdr_type;
  logic [2:0]           hdr_size;
  logic [2:0]           hdr_off;
  logic [lg_mem_lp-1:0] hdr_word;
  assign hdr_type = hdr_q[3:0];
  assign hdr_off  = hdr_q[6:4];
  assign hdr_word = hdr_q[7 +: lg_mem_lp];
  assign hdr_size = hdr_q[size_lsb_lp +: 3];

  logic cmd_is_wr, hdr_is_rd;
  assign cmd_is_wr = (mem_cmd_header_i[3:0] == MSG_WR) || (mem_cmd_header_i[3:0] == MSG_UC_WR);
  assign hdr_is_rd = (hdr_type == MSG_RD) || (hdr_type == MSG_UC_RD);

  logic cmd_hdr_fire, wdata_fire, rhdr_fire, rdata_fire;
  assign cmd_hdr_fire = cmd_hdr_rdy_q & mem_cmd_header_v_i;
  assign wdata_fire   = cmd_dat_rdy_q & mem_cmd_data_v_i;
  assign rhdr_fire    = resp_hdr_v_q  & mem_resp_header_ready_i;
  assign rdata_fire   = resp_dat_v_q  & mem_resp_data_ready_i;

  // Beat count and wrapped beat address: the block-aligned upper bits stay
  // fixed while the in-block offset advances modulo the block size.
  logic [4:0]           beats;
  logic                 last_beat;
  logic [lg_mem_lp-1:0] mem_idx;
  assign beats     = (hdr_size <= 3'd3) ? 5'd1 : 5'(5'd1 << (hdr_size - 3'd3));
  assign last_beat = (cnt_q == beats - 5'd1);
  assign mem_idx   = (hdr_word & ~blk_mask_lp)
                   | ((hdr_word + lg_mem_lp'(cnt_q)) & blk_mask_lp);

  // Write byte enables and lane-aligned write data; sub-dword writes land at
  // addr[2:0] and leave the other lanes untouched.
  logic [bytes_lp-1:0]      wr_be;
  logic [dword_width_p-1:0] wr_data;
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_be   = '1;
    wr_data = mem_cmd_data_i;
    if (hdr_size < 3'd3) begin
      wr_data = mem_cmd_data_i << {hdr_off, 3'b000};
      for (int b = 0; b < bytes_lp; b++) begin
        wr_be[b] = (b >= int'(hdr_off)) && (b < int'(hdr_off) + (1 << hdr_size));
      end
    end
  end

  // Next-state logic for the transaction FSM and beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    case (state_q)
      IDLE: if (cmd_hdr_fire) begin
        hdr_d   = mem_cmd_header_i;
        cnt_d   = '0;
        state_d = cmd_is_wr ? WDATA : RHDR;
      end
      WDATA: if (wdata_fire) begin
        cnt_d = last_beat ? '0 : cnt_q + 5'd1;
        if (last_beat) state_d = RHDR;
      end
      RHDR: if (rhdr_fire) begin
        cnt_d   = '0;
        state_d = hdr_is_rd ? RDATA : IDLE;
      end
      RDATA: if (rdata_fire) begin
        cnt_d = last_beat ? '0 : cnt_q + 5'd1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched header and registered handshake flags. The flags
  // clear in reset, so header ready rises on the first clock after release.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hdr_q         <= '0;
      cmd_hdr_rdy_q <= 1'b0;
      cmd_dat_rdy_q <= 1'b0;
      resp_hdr_v_q  <= 1'b0;
      resp_dat_v_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      cmd_hdr_rdy_q <= (state_d == IDLE);
      cmd_dat_rdy_q <= (state_d == WDATA);
      resp_hdr_v_q  <= (state_d == RHDR);
      resp_dat_v_q  <= (state_d == RDATA);
    end
  end

  // Byte-masked write port of the memory array.
  // NOTE: the memory array has no reset; contents survive reset and only the control state is cleared.
  always_ff @(posedge clk_i) begin
    if (wdata_fire) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (wr_be[b]) mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign mem_cmd_header_ready_o = cmd_hdr_rdy_q;
  assign mem_cmd_data_ready_o   = cmd_dat_rdy_q;
  assign mem_resp_header_v_o    = resp_hdr_v_q;
  assign mem_resp_data_v_o      = resp_dat_v_q;
  assign mem_resp_header_o      = resp_hdr_v_q ? hdr_q : '0;
  assign mem_resp_data_o        = resp_dat_v_q ? mem_q[mem_idx] : '0;

endmodule

// File: tb/tb_bp_me_burst_mem_responder.sv
// Self-checking bench for bp_me_burst_mem_responder: directed scenarios plus
// random traffic, checked by a scoreboard fed from a byte-level memory model.
module tb_bp_me_burst_mem_responder;

  localparam int PADDR   = 40;
  localparam int DW      = 64;
  localparam int BW      = 512;
  localparam int MEM_ELS = 1024;
  localparam int PW      = 16;
  localparam int HW      = PW + 3 + PADDR + 4;
  localparam int B       = BW / 64;

  logic          clk_i     = 1'b0;
  logic          reset_n_i = 1'b1;
  logic [HW-1:0] cmd_hdr   = '0;
  logic          cmd_hdr_v = 1'b0;
  logic          cmd_hdr_rdy;
  logic [DW-1:0] cmd_dat   = '0;
  logic          cmd_dat_v = 1'b0;
  logic          cmd_dat_rdy;
  logic [HW-1:0] resp_hdr;
  logic          resp_hdr_v;
  logic          resp_hdr_rdy = 1'b0;
  logic [DW-1:0] resp_dat;
  logic          resp_dat_v;
  logic          resp_dat_rdy = 1'b0;

  bp_me_burst_mem_responder #(
    .paddr_width_p(PADDR), .dword_width_p(DW), .block_width_p(BW),
    .mem_els_p(MEM_ELS), .payload_width_p(PW)
  ) dut (
    .clk_i                  (clk_i),
    .reset_n_i              (reset_n_i),
    .mem_cmd_header_i       (cmd_hdr),
    .mem_cmd_header_v_i     (cmd_hdr_v),
    .mem_cmd_header_ready_o (cmd_hdr_rdy),
    .mem_cmd_data_i         (cmd_dat),
    .mem_cmd_data_v_i       (cmd_dat_v),
    .mem_cmd_data_ready_o   (cmd_dat_rdy),
    .mem_resp_header_o      (resp_hdr),
    .mem_resp_header_v_o    (resp_hdr_v),
    .mem_resp_header_ready_i(resp_hdr_rdy),
    .mem_resp_data_o        (resp_dat),
    .mem_resp_data_v_o      (resp_dat_v),
    .mem_resp_data_ready_i  (resp_dat_rdy)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]    mdl [MEM_ELS*8];
  logic [HW-1:0] exp_hdr[$];
  logic [DW-1:0] exp_dat[$];
  logic [DW-1:0] dir_exp[$];
  logic [DW-1:0] wbeats[$];
  bit            hold_data = 1'b0;

  function automatic int nbeats(input int size);
    return (size <= 3) ? 1 : (1 << (size - 3));
  endfunction

  function automatic int word_idx(input logic [PADDR-1:0] a, input int k);
    longint w0 = longint'(a) / 8;
    longint w  = (w0 / B) * B + (w0 + k) % B;
    return int'(w % MEM_ELS);
  endfunction

  function automatic logic [DW-1:0] mdl_word(input int idx);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mdl[idx*8 + i];
    return r;
  endfunction

  function automatic void mdl_write(input logic [PADDR-1:0] a, input int size, input int k,
                                    input logic [DW-1:0] d);
    int idx = word_idx(a, k);
    int off = int'(a % 8);
    if (size >= 3) begin
      for (int i = 0; i < 8; i++) mdl[idx*8 + i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < (1 << size); i++)
        if (off + i < 8) mdl[idx*8 + off + i] = d[8*i +: 8];
    end
  endfunction

  function automatic logic [HW-1:0] mk_hdr(input int mt, input int size,
                                          input logic [PADDR-1:0] a, input logic [PW-1:0] pl);
    return {pl, 3'(size), a, 4'(mt)};
  endfunction

  // ---------------- response-ready driver ----------------
  initial forever begin
    @(posedge clk_i); #2;
    resp_hdr_rdy = ($urandom % 4) != 0;
    resp_dat_rdy = hold_data ? 1'b0 : (($urandom % 4) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  logic [HW-1:0] last_hdr;
  logic [DW-1:0] last_dat;
  bit hdr_stall = 1'b0, dat_stall = 1'b0;

  initial forever begin
    @(negedge clk_i);
    if (!reset_n_i) begin
      hdr_stall = 1'b0;
      dat_stall = 1'b0;
      continue;
    end
    if (hdr_stall) check("resp_hdr_held", {resp_hdr_v, resp_hdr}, {1'b1, last_hdr});
    if (dat_stall) check("resp_dat_held", {resp_dat_v, resp_dat}, {1'b1, last_dat});
    hdr_stall = 1'b0;
    dat_stall = 1'b0;
    if (resp_hdr_v) begin
      if (resp_hdr_rdy) begin
        if (exp_hdr.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_hdr_unexpected: got %0h expected no response", resp_hdr);
        end else check("resp_hdr", resp_hdr, exp_hdr.pop_front());
      end else begin
        hdr_stall = 1'b1;
        last_hdr  = resp_hdr;
      end
    end
    if (resp_dat_v) begin
      if (resp_dat_rdy) begin
        if (exp_dat.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_dat_unexpected: got %0h expected no beat", resp_dat);
        end else check("resp_dat", resp_dat, exp_dat.pop_front());
      end else begin
        dat_stall = 1'b1;
        last_dat  = resp_dat;
      end
    end
  end

  // ---------------- command drivers ----------------
  task automatic hs_hdr(input logic [HW-1:0] h, output bit ok);
    int n = 0;
    bit hs = 1'b0;
    cmd_hdr   = h;
    cmd_hdr_v = 1'b1;
    while (!hs && n < 300) begin
      @(negedge clk_i); hs = cmd_hdr_rdy;
      @(posedge clk_i); #1; n++;
    end
    cmd_hdr_v = 1'b0;
    check("cmd_hdr_accepted", hs, 1'b1);
    ok = hs;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, output bit ok);
    int n = 0;
    bit hs = 1'b0;
    repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
    cmd_dat   = d;
    cmd_dat_v = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk_i); hs = cmd_dat_rdy;
      @(posedge clk_i); #1; n++;
    end
    cmd_dat_v = 1'b0;
    check("cmd_dat_accepted", hs, 1'b1);
    ok = hs;
  endtask

  task automatic issue(input int mt, input int size, input logic [PADDR-1:0] a,
                       input logic [PW-1:0] pl);
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    int  nb;
    bit  ok, is_wr, is_rd;
    h     = mk_hdr(mt, size, a, pl);
    nb    = nbeats(size);
    is_wr = (mt == 1) || (mt == 3);
    is_rd = (mt == 0) || (mt == 2);
    if (!is_wr) begin
      exp_hdr.push_back(h);
      if (is_rd)
        for (int k = 0; k < nb; k++)
          exp_dat.push_back(dir_exp.size() != 0 ? dir_exp.pop_front() : mdl_word(word_idx(a, k)));
    end
    hs_hdr(h, ok);
    if (!ok) return;
    if (!is_wr) begin
      check("rhdr_latency_read", resp_hdr_v, 1'b1);
    end else begin
      for (int k = 0; k < nb; k++) begin
        d = (wbeats.size() != 0) ? wbeats.pop_front() : {$urandom, $urandom};
        if (k == nb - 1) exp_hdr.push_back(h);
        send_beat(d, ok);
        if (!ok) return;
        mdl_write(a, size, k, d);
      end
      check("rhdr_latency_write", resp_hdr_v, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_hdr.size() != 0 || exp_dat.size() != 0 || !cmd_hdr_rdy) && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    check("drained", 32'(exp_hdr.size() + exp_dat.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_hdr_rdy"}, cmd_hdr_rdy, 1'b0);
    check({tag, "_cmd_dat_rdy"}, cmd_dat_rdy, 1'b0);
    check({tag, "_resp_hdr_v"},  resp_hdr_v,  1'b0);
    check({tag, "_resp_dat_v"},  resp_dat_v,  1'b0);
    check({tag, "_resp_hdr"},    resp_hdr,    '0);
    check({tag, "_resp_dat"},    resp_dat,    '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n;
    logic [DW-1:0] d;

    #1 reset_n_i = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("post_reset_hdr_rdy", cmd_hdr_rdy, 1'b1);

    // A data beat offered in IDLE must not be accepted.
    cmd_dat   = 64'h1234;
    cmd_dat_v = 1'b1;
    @(negedge clk_i);
    check("idle_dat_rdy", cmd_dat_rdy, 1'b0);
    @(posedge clk_i); #1;
    cmd_dat_v = 1'b0;

    // Preload the low 2 KiB so every later read hits defined data.
    for (int i = 0; i < 32; i++) issue(1, 6, PADDR'(i * 64), PW'($urandom));

    // 1: single-beat write then read-back.
    wbeats.push_back(64'hDEADBEEF_01234567);
    issue(1, 3, 'h80, 16'hA001);
    dir_exp.push_back(64'hDEADBEEF_01234567);
    issue(0, 3, 'h80, 16'hA002);

    // 2: full-block write, then wrapped read starting at word 3.
    for (int i = 0; i < 8; i++) wbeats.push_back(DW'(64'h10 + i));
    issue(1, 6, 'h100, 16'hB001);
    for (int i = 0; i < 8; i++) dir_exp.push_back(DW'(64'h10 + (i + 3) % 8));
    issue(0, 6, 'h118, 16'hB002);

    // 3: partial uncached write into a filled word.
    wbeats.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    issue(1, 3, 'h40, 16'hC001);
    wbeats.push_back(64'h1234_5678_9ABC_ABCD);
    issue(3, 1, 'h42, 16'hC002);
    dir_exp.push_back(64'hFFFF_FFFF_ABCD_FFFF);
    issue(2, 3, 'h40, 16'hC003);

    // 4: burst read with the data channel stalled for 5 cycles.
    issue(0, 6, 'h100, 16'hD001);
    n = 0;
    while (!resp_dat_v && n < 50) begin @(posedge clk_i); #1; n++; end
    check("stall_read_started", resp_dat_v, 1'b1);
    hold_data = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 hold_data = 1'b0;
    wait_idle();

    // 5: unsupported type gets a header-only response, then a new command.
    issue(7, 3, 'h80, 16'hE001);
    issue(0, 3, 'h80, 16'hE002);
    wait_idle();

    // 6: reset in the middle of a write burst.
    hs_hdr(mk_hdr(1, 6, 'h200, 16'hF001), ok);
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom};
      send_beat(d, ok);
      mdl_write('h200, 6, k, d);
    end
    reset_n_i = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk_i); @(posedge clk_i); #1;
    check_reset_outputs("midrst_held");
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("midrst_hdr_rdy", cmd_hdr_rdy, 1'b1);
    repeat (20) @(posedge clk_i);
    #1 check("midrst_no_resp", resp_hdr_v, 1'b0);
    issue(0, 6, 'h200, 16'hF002);

    // Random traffic, including aliased addresses above the memory size.
    for (int t = 0; t < 150; t++) begin
      int sel, mt, size;
      logic [PADDR-1:0] a;
      sel  = $urandom % 16;
      mt   = (sel < 5) ? 0 : (sel < 7) ? 2 : (sel < 11) ? 1 : (sel < 13) ? 3 : 4 + ($urandom % 12);
      size = $urandom % 7;
      a    = PADDR'(($urandom % 2048) & ~((1 << ((size < 3) ? size : 3)) - 1));
      a    = a + PADDR'(($urandom % 16) * 8192);
      issue(mt, size, a, PW'($urandom));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_me_burst_mem_responder.md
Name: bp_me_burst_mem_responder

Overview:
- Memory-side endpoint of the CCE-MEM interface using the BP Burst protocol (ready&valid header and data channels).
- Accepts mem_cmd headers plus write-data beats from a CCE and services them against an internal dword-wide memory.
- Returns mem_resp headers plus read-data beats.
- Used as the memory end in CCE unit benches and small single-core test systems.

Parameters:
- paddr_width_p, 40, physical address width.
- dword_width_p, 64, data beat width in bits; fixed at 64.
- block_width_p, 512, cache block width; sets the wrap boundary for multi-beat bursts.
- mem_els_p, 1024, memory depth in dwords; must be a power of 2.
- payload_width_p, 16, opaque header payload, echoed unchanged.
- header_width_lp, derived, equals payload_width_p+3+paddr_width_p+4.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- mem_cmd_header_i  in  header_width_lp  command header, packed {payload, size[2:0], addr, msg_type[3:0]}, msg_type in the LSBs.
- mem_cmd_header_v_i  in  1  command header valid.
- mem_cmd_header_ready_o  out  1  command header ready.
- mem_cmd_data_i  in  dword_width_p  write data beat.
- mem_cmd_data_v_i  in  1  write data beat valid.
- mem_cmd_data_ready_o  out  1  write data beat ready.
- mem_resp_header_o  out  header_width_lp  response header; same layout as the command header.
- mem_resp_header_v_o  out  1  response header valid.
- mem_resp_header_ready_i  in  1  response header ready.
- mem_resp_data_o  out  dword_width_p  read data beat.
- mem_resp_data_v_o  out  1  read data beat valid.
- mem_resp_data_ready_i  in  1  read data beat ready.

Behaviour:
- One clock domain (clk_i). reset_n_i is asynchronous, active-low.

Reset:
- State returns to IDLE and the beat counter clears to 0.
- While reset_n_i is low, every valid and ready output is 0, and mem_resp_header_o and mem_resp_data_o are 0.
- Memory array contents are not reset.
- Reset asserted mid-transaction abandons that transaction immediately. No response is issued for it.

Decode:
- msg_type encodings: 0 = rd, 1 = wr, 2 = uc_rd, 3 = uc_wr. Any other value is unsupported.
- size encodes 2^size bytes, for size 0 to 6.
- beats = 1 when size <= 3; otherwise 2^(size-3).
- Base word index w0 = addr[..:3].
- Beat k addresses word (w0 & ~(B-1)) | ((w0+k) & (B-1)), where B = block_width_p/64. Bursts therefore wrap within the block-aligned region (critical word first).
- The memory index is that word modulo mem_els_p.

FSM:
- IDLE:
  - mem_cmd_header_ready_o = 1.
  - On header handshake: latch the header and clear the counter.
  - wr or uc_wr goes to WDATA. rd or uc_rd goes to RHDR. Unsupported types go to RHDR.
- WDATA:
  - mem_cmd_data_ready_o = 1.
  - Each handshake writes the current beat address and increments the counter.
  - For size < 3, only the 2^size low bytes of the beat are written, into byte lanes starting at addr[2:0]. Other lanes are unchanged.
  - The handshake on beat beats-1 goes to RHDR.
- RHDR:
  - mem_resp_header_v_o = 1; mem_resp_header_o = latched header, unmodified.
  - On handshake: rd and uc_rd go to RDATA with the counter at 0. Everything else returns to IDLE.
- RDATA:
  - mem_resp_data_v_o = 1; mem_resp_data_o = full dword at the current beat address, read combinationally.
  - Each handshake increments the counter. The handshake on beat beats-1 returns to IDLE.

Handshake and timing rules:
- Only one transaction is in flight. Command header and data ready are both 0 outside IDLE and WDATA respectively.
- Data beats offered while in IDLE are not accepted.
- Valid outputs never deassert without a handshake. Output data is stable while valid is high and ready is low.
- Read latency: command header handshake in cycle N gives mem_resp_header_v_o in cycle N+1. The first data beat is valid in the cycle after the response header handshake.
- Write latency: last data beat handshake in cycle M gives the response header valid in cycle M+1.
- Read-after-write to the same address returns the written data.

Test Plan:
1. Reset, then wr size=3 addr=0x80 data 0xDEADBEEF_01234567, then rd size=3 addr=0x80 -> response header echoes each command header; read beat = 0xDEADBEEF_01234567; response header valid exactly 1 cycle after command acceptance.
2. wr size=6 addr=0x100 with beats 0..7 = 0x10..0x17, then rd size=6 addr=0x118 -> 8 read beats in order 0x13,0x14,0x15,0x16,0x17,0x10,0x11,0x12 (wrap).
3. Fill word 0x40 with 0xFFFF_FFFF_FFFF_FFFF, then uc_wr size=1 addr=0x42 data=0xABCD -> uc_rd size=3 addr=0x40 returns 0xFFFF_FFFF_ABCD_FFFF.
4. Hold mem_resp_data_ready_i low for 5 cycles during a size=6 read -> valid held high, data stable; no beat lost or repeated; 8 beats total.
5. msg_type=7 command -> single response header echoing the command, no data beats; the block then accepts a new header.
6. Assert reset_n_i during WDATA after beat 3 of 8 -> all valids and readies are 0 during reset; after release, mem_cmd_header_ready_o = 1 and no response is issued for the aborted write.
